// File: rtl/ph_fifo_pkg.sv
// ph_fifo_pkg: shared tube constants and the clog2 helper used to size FIFO pointers and counters.
package ph_fifo_pkg;

    localparam int PH_DEFAULT_WIDTH = 8;
    localparam int PH_R1_DEPTH = 24;
    localparam logic [7:0] PH_RESET_DATA = 8'h41;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/tube_fifo_ram.sv
// tube_fifo_ram: DEPTH x WIDTH storage, synchronous write, asynchronous read.
module tube_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 24,
    parameter int AW = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ph_fifo.sv
// ph_fifo: parasite-to-host first-word-fall-through FIFO with count, flush and sticky error flags.
// Defining PH_FIFO_IRQ_EN adds the registered occupancy interrupt h_irq.
module ph_fifo
    import ph_fifo_pkg::*;
#(
    parameter int WIDTH = PH_DEFAULT_WIDTH,
    parameter int DEPTH = PH_R1_DEPTH,
    parameter logic [WIDTH-1:0] RESET_DATA = WIDTH'(PH_RESET_DATA),
    parameter int IRQ_THRESH = 1,
    localparam int CW = clog2(DEPTH + 1),
    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p_wr_en,
    input  logic [WIDTH-1:0] p_data,
    input  logic             p_flush,
    input  logic             h_rd_en,
    output logic [WIDTH-1:0] h_data,
    output logic             h_data_available,
    output logic             p_full,
    output logic [CW-1:0]    count,
    output logic             p_overrun,
    output logic             h_underrun,
    output logic             h_irq
);

    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [CW-1:0] count_next;
    logic [WIDTH-1:0] rdata, h_data_next;
    logic push_ok, pop_ok, ovr_hit, und_hit;

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign push_ok = p_wr_en && (!p_full || h_rd_en) && !rst && !p_flush;
    assign pop_ok = h_rd_en && h_data_available;
    assign ovr_hit = p_wr_en && p_full && !h_rd_en;
    assign und_hit = h_rd_en && !h_data_available;

    always_comb begin
        wr_ptr_next = push_ok ? ((wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1)) : wr_ptr;
        rd_ptr_next = pop_ok ? ((rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1)) : rd_ptr;
        count_next = (push_ok && !pop_ok) ? count + CW'(1) :
                     (pop_ok && !push_ok) ? count - CW'(1) : count;
        // The new head may be the word being written this cycle, which the RAM cannot show yet.
        h_data_next = (count_next == '0) ? h_data :
                      (push_ok && wr_ptr == rd_ptr_next) ? p_data : rdata;
    end

    tube_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (p_data),
        .raddr (rd_ptr_next),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst || p_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            h_data <= RESET_DATA;
            h_data_available <= 1'b0;
            p_full <= 1'b0;
            p_overrun <= 1'b0;
            h_underrun <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            count <= count_next;
            h_data <= h_data_next;
            h_data_available <= count_next != '0;
            p_full <= count_next == CW'(DEPTH);
            p_overrun <= p_overrun | ovr_hit;
            h_underrun <= h_underrun | und_hit;
        end
    end

`ifdef PH_FIFO_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst || p_flush) h_irq <= 1'b0;
        else h_irq <= int'(count_next) >= IRQ_THRESH;
    end
`else
    logic unused_irq_thresh;
    assign unused_irq_thresh = ^IRQ_THRESH;
    assign h_irq = 1'b0;
`endif

endmodule

// File: tb/tb_ph_fifo.sv
// tb_ph_fifo: table vectors plus queue scoreboard for ph_fifo (DEPTH=24, IRQ_THRESH=4).
module tb_ph_fifo;
    import ph_fifo_pkg::*;

    localparam int W = 8;
    localparam int D = 24;
    localparam int CW = clog2(D + 1);
    localparam int TH = 4;

    logic clk = 1'b0, rst = 1'b1, p_wr_en = 1'b0, p_flush = 1'b0, h_rd_en = 1'b0;
    logic [W-1:0] p_data = '0;
    logic [W-1:0] h_data;
    logic h_data_available, p_full, p_overrun, h_underrun, h_irq;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    ph_fifo #(.WIDTH(W), .DEPTH(D), .RESET_DATA(8'h41), .IRQ_THRESH(TH)) dut (
        .clk              (clk),
        .rst              (rst),
        .p_wr_en          (p_wr_en),
        .p_data           (p_data),
        .p_flush          (p_flush),
        .h_rd_en          (h_rd_en),
        .h_data           (h_data),
        .h_data_available (h_data_available),
        .p_full           (p_full),
        .count            (count),
        .p_overrun        (p_overrun),
        .h_underrun       (h_underrun),
        .h_irq            (h_irq)
    );

    int tests = 0, fails = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] hd = 8'h41;
    bit ovr = 0, und = 0;

    typedef struct {
        bit wr, rd, fl, rs;
        logic [W-1:0] d;
        int cnt;
        bit av, fu, ov, un;
        logic [W-1:0] hd;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic step(input bit wr, input bit rd, input bit fl, input bit rs, input logic [W-1:0] d);
        bit empty, full, popq, pushq, exp_irq;
        p_wr_en = wr;
        h_rd_en = rd;
        p_flush = fl;
        rst = rs;
        p_data = d;
        if (!rs && !fl && rd && q.size() > 0) chk("pop_data", int'(h_data), int'(q[0]));
        @(posedge clk);
        #1;
        if (rs || fl) begin
            q.delete();
            hd = 8'h41;
            ovr = 0;
            und = 0;
        end else begin
            empty = q.size() == 0;
            full = q.size() == D;
            popq = rd && !empty;
            pushq = wr && (!full || rd);
            if (wr && full && !rd) ovr = 1;
            if (rd && empty) und = 1;
            if (popq) void'(q.pop_front());
            if (pushq) q.push_back(d);
            if (q.size() > 0) hd = q[0];
        end
`ifdef PH_FIFO_IRQ_EN
        exp_irq = q.size() >= TH;
`else
        exp_irq = 0;
`endif
        chk("h_data", int'(h_data), int'(hd));
        chk("count", int'(count), q.size());
        chk("h_data_available", int'(h_data_available), int'(q.size() > 0));
        chk("p_full", int'(p_full), int'(q.size() == D));
        chk("p_overrun", int'(p_overrun), int'(ovr));
        chk("h_underrun", int'(h_underrun), int'(und));
        chk("h_irq", int'(h_irq), int'(exp_irq));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0);
    endtask

    initial begin
        tv[0] = '{1, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h41};
        tv[1] = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h41};
        tv[2] = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h41};
        tv[3] = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h41};
        tv[4] = '{1, 0, 0, 0, 8'h12, 1, 1, 0, 0, 0, 8'h12};
        tv[5] = '{0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h12};
        tv[6] = '{0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'h12};
        tv[7] = '{0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h41};
        for (int i = 0; i < 8; i++) begin
            step(tv[i].wr, tv[i].rd, tv[i].fl, tv[i].rs, tv[i].d);
            chk("tv_count", int'(count), tv[i].cnt);
            chk("tv_avail", int'(h_data_available), int'(tv[i].av));
            chk("tv_full", int'(p_full), int'(tv[i].fu));
            chk("tv_overrun", int'(p_overrun), int'(tv[i].ov));
            chk("tv_underrun", int'(h_underrun), int'(tv[i].un));
            chk("tv_h_data", int'(h_data), int'(tv[i].hd));
        end

        // fill, overrun, drain; second pass starts at pointer offset 10
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 10 * pass; i++) step(1, 0, 0, 0, 8'hF0);
            for (int i = 0; i < 10 * pass; i++) step(0, 1, 0, 0, '0);
            for (int i = 0; i < D; i++) step(1, 0, 0, 0, W'(i));
            step(1, 0, 0, 0, 8'hAA);
            chk("full_count", int'(count), D);
            chk("full_overrun", int'(p_overrun), 1);
            for (int i = 0; i < D; i++) begin
                chk("drain_seq", int'(h_data), i);
                step(0, 1, 0, 0, '0);
            end
            chk("drain_empty", int'(h_data_available), 0);
            step(0, 0, 1, 0, '0);
        end

        // simultaneous push+pop at full and at empty
        for (int i = 0; i < D; i++) step(1, 0, 0, 0, W'(8'h30 + i));
        step(1, 1, 0, 0, 8'h55);
        chk("both_full_count", int'(count), D);
        chk("both_full_ovr", int'(p_overrun), 0);
        for (int i = 0; i < D - 1; i++) step(0, 1, 0, 0, '0);
        chk("last_is_55", int'(h_data), 8'h55);
        step(0, 1, 0, 0, '0);
        step(1, 1, 0, 0, 8'h66);
        chk("both_empty_count", int'(count), 1);
        chk("both_empty_und", int'(h_underrun), 1);

        // flush and reset mid-burst with a concurrent write
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) step(1, 0, 0, 0, W'(8'h70 + i));
            step(1, 0, k == 0, k == 1, 8'h99);
            chk("clr_count", int'(count), 0);
            chk("clr_h_data", int'(h_data), 8'h41);
            idle();
        end

        // interrupt threshold
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, W'(i));
        step(1, 0, 0, 0, 8'h03);
        step(0, 1, 0, 0, '0);
        step(0, 0, 1, 0, '0);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 63) == 0, 0, W'($urandom));
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 63) == 0, 0, W'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
